uart_tx_responder: RTL and testbench

- Memory-mapped UART transmitter. It is the responder end of the CPU data-memory bus (ce/we/addr/sel/data).
- Sits beside the data RAM in the SOPC; upstream address decode drives its ce_i.
- CPU writes bytes into a TX FIFO; an 8N1 serialiser drains it onto tx_o.
- Level interrupt irq_o feeds one bit of the CPU int_i vector.

---
 rtl/uart_tx_responder.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_uart_tx_responder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_responder
// Purpose  : Memory-mapped 8N1 UART transmitter sitting on the CPU
//            data-memory bus. The CPU pushes bytes into a circular TX FIFO.
//            A serialiser drains the FIFO onto tx_o. A level interrupt
//            signals "FIFO drained and line idle".
// Options  : UART_TX_PARITY_EN - when defined, a parity bit (even/odd
//            selected by CTRL[2]) is inserted between the data and stop bits.
// Ports    : clk    - system clock, all state on rising edge
//            rst    - synchronous, active-low reset
//            ce_i   - bus select for this block
//            we_i   - 1 = write, 0 = read
//            addr_i - byte address, only [3:2] decoded
//            sel_i  - byte enables, sel_i[0] covers data_i[7:0]
//            data_i - write data
//            data_o - read data (combinational, 0 when not selected)
//            tx_o   - serial line, idle high
//            irq_o  - level interrupt, active high
// Register map (addr_i[3:2]):
//            0 TXDATA  (W)   push data_i[7:0]
//            1 STATUS  (R)   [0] busy [1] full [2] empty [3] overflow (W1C)
//                            [8+FIFO_AW:8] FIFO count
//            2 CTRL    (R/W) [0] tx_en [1] irq_en [2] parity-odd
//            3 BAUDDIV (R/W) [15:0] cycles per bit, 0 behaves as 1
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_responder #(
    parameter int          FIFO_AW = 3,
    parameter logic [15:0] DIV_RST = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int                 c_DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   c_DEPTH_CNT = (FIFO_AW + 1)'(c_DEPTH);
    localparam logic [FIFO_AW-1:0] c_PTR_ONE   = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   c_CNT_ONE   = (FIFO_AW + 1)'(1);
`ifdef UART_TX_PARITY_EN
    localparam int                 c_CTRL_W    = 3;
`else
    localparam int                 c_CTRL_W    = 2;
`endif

    localparam logic [1:0] c_A_TXDATA  = 2'd0;
    localparam logic [1:0] c_A_STATUS  = 2'd1;
    localparam logic [1:0] c_A_CTRL    = 2'd2;
    localparam logic [1:0] c_A_BAUDDIV = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [c_CTRL_W-1:0] r_ctrl;
    logic [15:0]         r_div;
    logic                r_ovf;
    logic [7:0]          r_mem [c_DEPTH];
    logic [FIFO_AW-1:0]  r_wptr;
    logic [FIFO_AW-1:0]  r_rptr;
    logic [FIFO_AW:0]    r_count;

    state_t              r_state;
    logic                r_tx;
    logic                r_irq;
    logic [7:0]          r_shift;
    logic [15:0]         r_baud;
    logic [2:0]          r_bit;
`ifdef UART_TX_PARITY_EN
    logic                r_par;
`endif

    // ------------------------------------------------------------------
    // Decode and FIFO control
    // ------------------------------------------------------------------
    logic        w_wr;
    logic [1:0]  w_reg;
    logic        w_push_req;
    logic        w_push;
    logic        w_pop;
    logic        w_empty;
    logic        w_full;
    logic        w_busy;
    logic [7:0]  w_rd_byte;
    logic [15:0] w_period;
    logic [15:0] w_reload;
    logic [31:0] w_status;
    logic        w_unused_ok;

    assign w_wr       = ce_i & we_i;
    assign w_reg      = addr_i[3:2];
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_DEPTH_CNT);
    assign w_busy     = (r_state != ST_IDLE);
    assign w_push_req = w_wr & (w_reg == c_A_TXDATA) & sel_i[0];
    assign w_pop      = (r_state == ST_IDLE) & r_ctrl[0] & ~w_empty;
    // A push into a full FIFO still fits when the serialiser pops the same cycle.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_rd_byte  = r_mem[r_rptr];

    // A divisor of 0 behaves as 1; the baud counter counts reload..0.
    assign w_period   = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_reload   = w_period - 16'd1;

    assign w_unused_ok = &{1'b0, addr_i[31:4], addr_i[1:0], data_i[31:16], sel_i[3:2]};

    // ------------------------------------------------------------------
    // FIFO storage (data only, no reset needed: pointers define validity)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem[r_wptr] <= data_i[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Control registers, FIFO pointers, overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ctrl  <= '0;
            r_div   <= DIV_RST;
            r_ovf   <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (w_reg == c_A_STATUS) && sel_i[0] && data_i[3]) begin
                r_ovf <= 1'b0;
            end

            if (w_wr && (w_reg == c_A_CTRL) && sel_i[0]) begin
                r_ctrl <= data_i[c_CTRL_W-1:0];
            end

            if (w_wr && (w_reg == c_A_BAUDDIV)) begin
                if (sel_i[0]) begin
                    r_div[7:0] <= data_i[7:0];
                end
                if (sel_i[1]) begin
                    r_div[15:8] <= data_i[15:8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM with registered line and interrupt outputs.
    // The baud counter is reloaded from the live divisor at every bit
    // boundary, so a divisor change mid-frame applies from the next bit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
            r_irq   <= 1'b0;
            r_shift <= '0;
            r_baud  <= '0;
            r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_irq <= r_ctrl[1] & w_empty & ~w_busy;

            if (r_state == ST_IDLE) begin
                r_tx <= 1'b1;
                if (w_pop) begin
                    r_shift <= w_rd_byte;
                    r_baud  <= w_reload;
                    r_bit   <= '0;
                    r_tx    <= 1'b0;
                    r_state <= ST_START;
`ifdef UART_TX_PARITY_EN
                    // Parity is fixed when the byte is taken from the FIFO.
                    r_par   <= (^w_rd_byte) ^ r_ctrl[2];
`endif
                end
            end else if (r_baud != 16'd0) begin
                r_baud <= r_baud - 16'd1;
            end else begin
                r_baud <= w_reload;
                case (r_state)
                    ST_START: begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= '0;
                        r_state <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= ST_PAR;
`else
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end
                    ST_PAR: begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_tx    <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_tx    <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    always_comb begin
        w_status                 = '0;
        w_status[0]              = w_busy;
        w_status[1]              = w_full;
        w_status[2]              = w_empty;
        w_status[3]              = r_ovf;
        // Count is FIFO_AW+1 bits wide so a full FIFO reads its true depth.
        w_status[8+FIFO_AW:8]    = r_count;
    end

    always_comb begin
        data_o = '0;
        if (ce_i && !we_i) begin
            case (w_reg)
                c_A_STATUS:  data_o = w_status;
                c_A_CTRL:    data_o = 32'(r_ctrl);
                c_A_BAUDDIV: data_o = {16'd0, r_div};
                default:     data_o = '0;
            endcase
        end
    end

    assign tx_o  = r_tx;
    assign irq_o = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_responder
// Purpose  : Self-checking bench for uart_tx_responder. Bytes written to
//            TXDATA are queued as expected frames; a line monitor decodes
//            every frame on tx_o cycle by cycle and compares it with the
//            queue. Register reads and timing points are checked inline.
// Options  : UART_TX_PARITY_EN - enables the parity frame scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_responder;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        ce_i   = 1'b0;
    logic        we_i   = 1'b0;
    logic [31:0] addr_i = '0;
    logic [3:0]  sel_i  = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        tx_o;
    logic        irq_o;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    uart_tx_responder #(.FIFO_AW(3), .DIV_RST(16'd434)) dut (
        .clk    (clk),
        .rst    (rst),
        .ce_i   (ce_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .sel_i  (sel_i),
        .data_i (data_i),
        .data_o (data_o),
        .tx_o   (tx_o),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks      = 0;
    int         errors      = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         frames_done = 0;
    int         tb_p        = 434;
    logic       tb_odd      = 1'b0;
    logic       mon_en      = 1'b1;
    int         last_wr_cyc = 0;

    // ---------------- bus helpers (enter and leave on a falling edge) -----
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ce_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d; sel_i = s;
        last_wr_cyc = cyc;
        @(negedge clk);
        ce_i = 1'b0; we_i = 1'b0; sel_i = '0; data_i = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        ce_i = 1'b1; we_i = 1'b0; addr_i = a;
        #1 d = data_o;
        ce_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (frames_done < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (frames_done < n) begin
            errors++;
            $display("FAIL frame_timeout: frames seen %0d, needed %0d", frames_done, n);
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- line monitor ----------------------------------------
    task automatic rx_frame();
        logic [7:0]  b;
        logic [10:0] bits;
        logic [7:0]  got;
        int          p;
        int          bad_bit;
        p = tb_p;
        start_q.push_back(cyc);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: frame start at cycle %0d, expected no frame", cyc);
            b = 8'h00;
        end else begin
            b = exp_q.pop_front();
        end
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
        bits[9]   = (^b) ^ tb_odd;
`endif
        got     = '0;
        bad_bit = -1;
        for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < p; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                if (c == p / 2 && k >= 1 && k <= 8) got[k-1] = tx_o;
                if (tx_o !== bits[k] && bad_bit < 0) bad_bit = k;
            end
        end
        checks++;
        if (bad_bit >= 0) begin
            errors++;
            $display("FAIL rx_frame: bit %0d wrong, got byte %h, expected byte %h", bad_bit, got, b);
        end
        frames_done++;
    endtask

    initial begin : mon
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev === 1'b1 && tx_o === 1'b0) rx_frame();
            prev = tx_o;
        end
    end

    // ---------------- scenarios -------------------------------------------
    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx_o !== 1'b1)  begin errors++; $display("FAIL reset_tx: got %b expected 1", tx_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
        bus_read(32'h4, d);
        checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL reset_status: got %h expected 00000004", d); end
        bus_read(32'h8, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 00000000", d); end
        bus_read(32'hC, d);
        checks++; if (d !== 32'h0000_01B2) begin errors++; $display("FAIL reset_baud: got %h expected 000001b2", d); end
        bus_read(32'h0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h expected 00000000", d); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        bus_write(32'hC, 32'hFFFF_FF34, 4'b0001);
        bus_read(32'hC, d);
        checks++; if (d !== 32'h0000_0134) begin errors++; $display("FAIL baud_lane0: got %h expected 00000134", d); end
        bus_write(32'hC, 32'h0000_2200, 4'b0010);
        bus_read(32'hC, d);
        checks++; if (d !== 32'h0000_2234) begin errors++; $display("FAIL baud_lane1: got %h expected 00002234", d); end
        bus_write(32'hC, 32'hFFFF_FFFF, 4'b1100);
        bus_read(32'hC, d);
        checks++; if (d !== 32'h0000_2234) begin errors++; $display("FAIL baud_upper: got %h expected 00002234", d); end
        bus_write(32'h8, 32'hFFFF_FFFF, 4'b1111);
        bus_read(32'h8, d);
`ifdef UART_TX_PARITY_EN
        checks++; if (d !== 32'h7) begin errors++; $display("FAIL ctrl_mask: got %h expected 00000007", d); end
`else
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL ctrl_mask: got %h expected 00000003", d); end
`endif
        bus_write(32'h8, 32'h0, 4'b0001);
        ce_i = 1'b0; addr_i = 32'h4;
        #1;
        checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL read_no_ce: got %h expected 00000000", data_o); end
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [31:0] d;
        int p;
        bus_write(32'hC, 32'h4, 4'b0011);
        tb_p = 4;
        bus_write(32'h8, 32'h1, 4'b0001);
        exp_q.push_back(8'h55);
        bus_write(32'h0, 32'h55, 4'b0001);
        p = last_wr_cyc + 2;
        wait_until(p);
        checks++; if (tx_o !== 1'b0) begin errors++; $display("FAIL start_latency: tx got %b expected 0", tx_o); end
        wait_until(p + 20);
        bus_read(32'h4, d);
        checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL busy_mid: got %b expected 1", d[0]); end
        wait_until(p + 39);
        bus_read(32'h4, d);
        checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL busy_last: got %b expected 1", d[0]); end
        bus_read(32'h4, d);
        checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL busy_after: got %h expected 00000004", d); end
        wait_frames(1, 200);
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] d;
        int base;
        bus_write(32'h8, 32'h0, 4'b0001);
        bus_write(32'h0, 32'hAA, 4'b1110);
        bus_read(32'h4, d);
        checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL sel0_ignored: got %h expected 00000004", d); end
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(8'(i));
            bus_write(32'h0, 32'(i), 4'b0001);
        end
        bus_read(32'h4, d);
        checks++; if (d !== 32'h0000_0802) begin errors++; $display("FAIL fifo_full: got %h expected 00000802", d); end
        bus_write(32'h0, 32'h09, 4'b0001);
        bus_read(32'h4, d);
        checks++; if (d !== 32'h0000_080A) begin errors++; $display("FAIL overflow_set: got %h expected 0000080a", d); end
        bus_write(32'h4, 32'h8, 4'b0001);
        bus_read(32'h4, d);
        checks++; if (d !== 32'h0000_0802) begin errors++; $display("FAIL overflow_clr: got %h expected 00000802", d); end
        start_q.delete();
        base = frames_done;
        bus_write(32'h8, 32'h1, 4'b0001);
        exp_q.push_back(8'h0A);
        bus_write(32'h0, 32'h0A, 4'b0001);
        bus_read(32'h4, d);
        checks++; if (d !== 32'h0000_0803) begin errors++; $display("FAIL push_pop_full: got %h expected 00000803", d); end
        wait_frames(base + 9, 9 * 50);
        for (int i = 0; i + 1 < start_q.size(); i++) begin
            checks++;
            if (start_q[i+1] - start_q[i] !== NBITS * 4 + 1) begin
                errors++;
                $display("FAIL frame_gap%0d: got %0d cycles expected %0d", i, start_q[i+1] - start_q[i], NBITS * 4 + 1);
            end
        end
        bus_read(32'h4, d);
        checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL drained: got %h expected 00000004", d); end
    endtask

    task automatic test_interrupt();
        int p;
        int c;
        bus_write(32'hC, 32'h2, 4'b0011);
        tb_p = 2;
        bus_write(32'h8, 32'h3, 4'b0001);
        @(negedge clk);
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_idle: got %b expected 1", irq_o); end
        exp_q.push_back(8'hA3);
        bus_write(32'h0, 32'hA3, 4'b0001);
        p = last_wr_cyc + 2;
        wait_until(p + 10);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_sending: got %b expected 0", irq_o); end
        wait_until(p + NBITS * 2);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_lag: got %b expected 0", irq_o); end
        @(negedge clk);
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_done: got %b expected 1", irq_o); end
        bus_write(32'h8, 32'h1, 4'b0001);
        c = last_wr_cyc;
        wait_until(c + 2);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_disable: got %b expected 0", irq_o); end
        wait_frames(frames_done, 10);
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        int p;
        int lows;
        bus_write(32'hC, 32'h8, 4'b0011);
        tb_p = 8;
        bus_write(32'h8, 32'h1, 4'b0001);
        mon_en = 1'b0;
        bus_write(32'h0, 32'h00, 4'b0001);
        p = last_wr_cyc + 2;
        wait_until(p + 19);
        checks++; if (tx_o !== 1'b0) begin errors++; $display("FAIL mid_frame_line: got %b expected 0", tx_o); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b expected 1", tx_o); end
        rst = 1'b1;
        bus_read(32'h4, d);
        checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL abort_status: got %h expected 00000004", d); end
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_o !== 1'b1) lows++;
        end
        checks++; if (lows !== 0) begin errors++; $display("FAIL no_resume: got %0d low cycles expected 0", lows); end
        mon_en = 1'b1;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int base;
        base = frames_done;
        bus_write(32'hC, 32'h2, 4'b0011);
        tb_p   = 2;
        tb_odd = 1'b1;
        bus_write(32'h8, 32'h5, 4'b0001);
        exp_q.push_back(8'h07);
        bus_write(32'h0, 32'h07, 4'b0001);
        wait_frames(base + 1, 60);
        tb_odd = 1'b0;
        bus_write(32'h8, 32'h1, 4'b0001);
        exp_q.push_back(8'h07);
        bus_write(32'h0, 32'h07, 4'b0001);
        wait_frames(base + 2, 60);
    endtask
`endif

    initial begin
        test_reset();
        test_regs();
        test_single_frame();
        test_fifo_overflow();
        test_interrupt();
        test_reset_midframe();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL leftover_frames: got %0d unsent expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
